// File: rtl/regfile_operand_unit_pkg.sv
// Shared CPU operand-path constants: select encodings for the ALU operand muxes.
package regfile_operand_unit_pkg;

   // ALU A source selects
   localparam logic       ALU_A_SEL_REG   = 1'b0;
   localparam logic       ALU_A_SEL_PC    = 1'b1;

   // ALU B source selects
   localparam logic [1:0] ALU_B_SEL_REG   = 2'd0;
   localparam logic [1:0] ALU_B_SEL_IMM16 = 2'd1;
   localparam logic [1:0] ALU_B_SEL_IMM22 = 2'd2;
   localparam logic [1:0] ALU_B_SEL_TWO   = 2'd3;

endpackage : regfile_operand_unit_pkg

// File: rtl/regfile_operand_unit_regfile.sv
// Register file storage: 2**ADDR_W x DATA_W entries, three combinational read
// ports and one synchronous write port. No entry is hardwired and reads do not
// bypass an in-flight write, so a same-cycle read returns the old value.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wsel_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] asel_i,
   input  logic [ADDR_W-1:0] bsel_i,
   input  logic [ADDR_W-1:0] csel_i,
   output logic [DATA_W-1:0] adata_o,
   output logic [DATA_W-1:0] bdata_o,
   output logic [DATA_W-1:0] cdata_o
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_r [NREGS];

   // Storage update: reset clears every entry at once and blocks writes;
   // otherwise the selected entry loads write data on an enabled edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_r[i] <= '0;
         end
      end else if (we_i) begin
         mem_r[wsel_i] <= wdata_i;
      end
   end

   // Read ports return stored contents only, never the pending write data.
   assign adata_o = mem_r[asel_i];
   assign bdata_o = mem_r[bsel_i];
   assign cdata_o = mem_r[csel_i];

endmodule : regfile

// File: rtl/regfile_operand_unit.sv
// Operand unit: register file plus the ALU A/B source muxes. The pc input is
// a word address and is zero-extended; immediates are sign-extended.
module regfile_operand_unit
   import regfile_operand_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wsel_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] asel_i,
   input  logic [ADDR_W-1:0] bsel_i,
   input  logic [ADDR_W-1:0] csel_i,
   input  logic              a_mux_sel_i,
   input  logic [1:0]        b_mux_sel_i,
   input  logic [DATA_W-3:0] pc_i,
   input  logic [15:0]       imm16_i,
   input  logic [21:0]       imm22_i,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [DATA_W-1:0] cdata_o
);

   logic [DATA_W-1:0] adata_s;
   logic [DATA_W-1:0] bdata_s;
   logic [DATA_W-1:0] pc_ext_s;
   logic [DATA_W-1:0] imm16_ext_s;
   logic [DATA_W-1:0] imm22_ext_s;
   logic [DATA_W-1:0] two_s;

   regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (we_i),
      .wsel_i  (wsel_i),
      .wdata_i (wdata_i),
      .asel_i  (asel_i),
      .bsel_i  (bsel_i),
      .csel_i  (csel_i),
      .adata_o (adata_s),
      .bdata_o (bdata_s),
      .cdata_o (cdata_o)
   );

   assign pc_ext_s    = {2'b00, pc_i};
   assign imm16_ext_s = {{(DATA_W-16){imm16_i[15]}}, imm16_i};
   assign imm22_ext_s = {{(DATA_W-22){imm22_i[21]}}, imm22_i};
   assign two_s       = DATA_W'(2);

   // ALU A source: register port A or zero-extended pc.
   always_comb begin
      alu_a_o = adata_s;
      if (a_mux_sel_i == ALU_A_SEL_PC) begin
         alu_a_o = pc_ext_s;
      end else begin
         alu_a_o = adata_s;
      end
   end

   // ALU B source: register port B, sign-extended immediates, or constant two.
   always_comb begin
      alu_b_o = bdata_s;
      case (b_mux_sel_i)
         ALU_B_SEL_REG:   alu_b_o = bdata_s;
         ALU_B_SEL_IMM16: alu_b_o = imm16_ext_s;
         ALU_B_SEL_IMM22: alu_b_o = imm22_ext_s;
         ALU_B_SEL_TWO:   alu_b_o = two_s;
         default:         alu_b_o = bdata_s;
      endcase
   end

endmodule : regfile_operand_unit

// File: tb/tb_regfile_operand_unit.sv
// Directed self-checking bench for regfile_operand_unit.
module tb_regfile_operand_unit;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        we_i;
   logic [3:0]  wsel_i;
   logic [31:0] wdata_i;
   logic [3:0]  asel_i;
   logic [3:0]  bsel_i;
   logic [3:0]  csel_i;
   logic        a_mux_sel_i;
   logic [1:0]  b_mux_sel_i;
   logic [29:0] pc_i;
   logic [15:0] imm16_i;
   logic [21:0] imm22_i;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [31:0] cdata_o;

   int tests_run = 0;
   int tests_failed = 0;

   regfile_operand_unit #(
      .DATA_W (32),
      .ADDR_W (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .we_i        (we_i),
      .wsel_i      (wsel_i),
      .wdata_i     (wdata_i),
      .asel_i      (asel_i),
      .bsel_i      (bsel_i),
      .csel_i      (csel_i),
      .a_mux_sel_i (a_mux_sel_i),
      .b_mux_sel_i (b_mux_sel_i),
      .pc_i        (pc_i),
      .imm16_i     (imm16_i),
      .imm22_i     (imm22_i),
      .alu_a_o     (alu_a_o),
      .alu_b_o     (alu_b_o),
      .cdata_o     (cdata_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge: one write, committed at the next posedge.
   task automatic write_reg(input logic [3:0] sel, input logic [31:0] data);
      we_i    = 1'b1;
      wsel_i  = sel;
      wdata_i = data;
      @(posedge clk_i);
      #1;
      we_i    = 1'b0;
      wdata_i = 32'h0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      we_i        = 1'b0;
      wsel_i      = 4'd0;
      wdata_i     = 32'h0;
      asel_i      = 4'd0;
      bsel_i      = 4'd0;
      csel_i      = 4'd0;
      a_mux_sel_i = 1'b0;
      b_mux_sel_i = 2'd0;
      pc_i        = 30'h0;
      imm16_i     = 16'h0;
      imm22_i     = 22'h0;

      // Reset state and writes ignored under reset
      #2;
      check("reset_cdata", cdata_o, 32'h0);
      we_i = 1'b1; wsel_i = 4'd9; wdata_i = 32'h1111_2222;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      we_i = 1'b0;
      csel_i = 4'd9;
      #1;
      check("reset_blocks_write", cdata_o, 32'h0);
      rst_ni = 1'b1;
      #1;

      // All registers zero after reset on every port
      for (int i = 0; i < 16; i++) begin
         asel_i = 4'(i); bsel_i = 4'(i); csel_i = 4'(i);
         #1;
         check($sformatf("zero_a_r%0d", i), alu_a_o, 32'h0);
         check($sformatf("zero_b_r%0d", i), alu_b_o, 32'h0);
         check($sformatf("zero_c_r%0d", i), cdata_o, 32'h0);
      end

      // Write r5: old value visible before the edge, new value after
      @(negedge clk_i);
      asel_i = 4'd5; we_i = 1'b1; wsel_i = 4'd5; wdata_i = 32'hDEAD_BEEF;
      #1;
      check("r5_before_edge", alu_a_o, 32'h0);
      @(posedge clk_i);
      #1;
      check("r5_after_edge", alu_a_o, 32'hDEAD_BEEF);
      we_i = 1'b0; wdata_i = 32'h1;
      @(posedge clk_i);
      #1;
      check("r5_no_we", alu_a_o, 32'hDEAD_BEEF);

      // pc mux and register operands
      @(negedge clk_i);
      write_reg(4'd3, 32'h12);
      write_reg(4'd7, 32'h34);
      a_mux_sel_i = 1'b1; pc_i = 30'h3FFF_FFFF; asel_i = 4'd3;
      #1;
      check("alu_a_pc", alu_a_o, 32'h3FFF_FFFF);
      a_mux_sel_i = 1'b0;
      #1;
      check("alu_a_r3", alu_a_o, 32'h12);
      bsel_i = 4'd7; b_mux_sel_i = 2'd0;
      #1;
      check("alu_b_r7", alu_b_o, 32'h34);

      // Immediate sign extension and constant two
      imm16_i = 16'h8001; imm22_i = 22'h20_0000;
      b_mux_sel_i = 2'd1; #1;
      check("imm16_neg", alu_b_o, 32'hFFFF_8001);
      b_mux_sel_i = 2'd2; #1;
      check("imm22_neg", alu_b_o, 32'hFFE0_0000);
      b_mux_sel_i = 2'd3; #1;
      check("const_two", alu_b_o, 32'h0000_0002);
      imm16_i = 16'h7FFF; b_mux_sel_i = 2'd1; #1;
      check("imm16_pos", alu_b_o, 32'h0000_7FFF);
      imm22_i = 22'h1F_FFFF; b_mux_sel_i = 2'd2; #1;
      check("imm22_pos", alu_b_o, 32'h001F_FFFF);
      b_mux_sel_i = 2'd0;

      // r0 is an ordinary register
      @(negedge clk_i);
      write_reg(4'd0, 32'h5555_AAAA);
      asel_i = 4'd0; #1;
      check("r0_writable", alu_a_o, 32'h5555_AAAA);
      asel_i = 4'd5; #1;
      check("r5_kept", alu_a_o, 32'hDEAD_BEEF);

      // Three ports on the same register
      @(negedge clk_i);
      write_reg(4'd15, 32'hA5A5_A5A5);
      asel_i = 4'd15; bsel_i = 4'd15; csel_i = 4'd15;
      #1;
      check("same_reg_a", alu_a_o, 32'hA5A5_A5A5);
      check("same_reg_b", alu_b_o, 32'hA5A5_A5A5);
      check("same_reg_c", cdata_o, 32'hA5A5_A5A5);

      // Asynchronous reset mid-cycle, racing a write
      @(posedge clk_i);
      #2;
      we_i = 1'b1; wsel_i = 4'd15; wdata_i = 32'h1234_5678;
      rst_ni = 1'b0;
      #1;
      check("async_rst_c", cdata_o, 32'h0);
      check("async_rst_a", alu_a_o, 32'h0);
      check("async_rst_b", alu_b_o, 32'h0);
      a_mux_sel_i = 1'b1; pc_i = 30'h0000_0ABC; #1;
      check("rst_pc_mux", alu_a_o, 32'h0000_0ABC);
      a_mux_sel_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("rst_beats_write", cdata_o, 32'h0);
      @(negedge clk_i);
      we_i = 1'b0;
      rst_ni = 1'b1;
      #1;
      check("after_rst_r15", cdata_o, 32'h0);
      csel_i = 4'd5; #1;
      check("after_rst_r5", cdata_o, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_regfile_operand_unit

// File: doc/regfile_operand_unit.md
REGFILE_OPERAND_UNIT -- requirements
Module: regfile_operand_unit

Interface
REQ-001 Parameter DATA_W, default 32, register and operand width; the pc input is DATA_W-2 bits.
REQ-002 Parameter ADDR_W, default 4, register select width; the file holds 2**ADDR_W registers.
REQ-003 clk_i  input  1  the only clock; every register updates on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous and active-low.
REQ-005 we_i  input  1  write enable.
REQ-006 wsel_i  input  ADDR_W  write register select.
REQ-007 wdata_i  input  DATA_W  write data.
REQ-008 asel_i / bsel_i / csel_i  input  ADDR_W each  select for read ports A, B and C.
REQ-009 a_mux_sel_i  input  1  ALU A source: 0 = port A, 1 = zero-extended pc.
REQ-010 b_mux_sel_i  input  2  ALU B source: 0 = port B, 1 = imm16 sign-extended, 2 = imm22 sign-extended, 3 = constant 2.
REQ-011 pc_i  input  DATA_W-2  word-address pc.
REQ-012 imm16_i  input  16  immediate; sign bit is imm16_i[15].
REQ-013 imm22_i  input  22  immediate; sign bit is imm22_i[21].
REQ-014 alu_a_o  output  DATA_W  selected ALU A operand.
REQ-015 alu_b_o  output  DATA_W  selected ALU B operand.
REQ-016 cdata_o  output  DATA_W  read port C data (branch test value).

Function
REQ-017 Register file SHALL be 2**ADDR_W x DATA_W, with three combinational read ports and one synchronous write port.
REQ-018 On each clk_i rising edge with we_i=1, register[wsel_i] SHALL load wdata_i; with we_i=0, no register SHALL change.
REQ-019 No register is hardwired; register 0 SHALL be writable like any other.
REQ-020 A read SHALL return the stored value combinationally; there is no write-to-read bypass.
REQ-021 During a write cycle, a read of the same register SHALL return the old value; the new value SHALL be visible after the edge.
REQ-022 Two or three read ports on the same register SHALL all return that register's value.
REQ-023 alu_a_o SHALL equal adata when a_mux_sel_i=0, and {2'b00, pc_i} when a_mux_sel_i=1.
REQ-024 alu_b_o SHALL follow b_mux_sel_i: 0 -> bdata; 1 -> imm16_i sign-extended to DATA_W; 2 -> imm22_i sign-extended to DATA_W; 3 -> DATA_W'd2.
REQ-025 Both muxes SHALL be purely combinational, with no latches; every select encoding is defined.
REQ-026 cdata_o SHALL equal register[csel_i] combinationally.

Reset
REQ-027 While rst_ni=0, every register SHALL clear to 0 immediately, independent of clk_i.
REQ-028 Writes SHALL be ignored while rst_ni=0.
REQ-029 Outputs during reset SHALL follow REQ-023 to REQ-026 using the cleared contents; for example, port reads return 0.
REQ-030 If rst_ni asserts in the same cycle as a write, reset SHALL win and the target register SHALL read 0.

Structure
REQ-031 The mux select encodings SHALL be named constants in the shared cpu package: ALU_A_SEL_REG/PC and ALU_B_SEL_REG/IMM16/IMM22/TWO.
REQ-032 The storage array SHALL be one sub-module, regfile, parameterised by DATA_W and ADDR_W.
REQ-033 The two operand muxes and the sign extension SHALL be inline logic in the top module.

Verification
REQ-034 Release reset, then read all 16 registers on ports A, B and C -> every read is 0x00000000.
REQ-035 Write 0xDEADBEEF to r5 with we_i=1, asel_i=5, a_mux_sel_i=0 -> alu_a_o is 0 before the edge and 0xDEADBEEF after it; a second cycle with we_i=0 and wdata_i=0x1 -> r5 unchanged.
REQ-036 With r3=0x12, r7=0x34, a_mux_sel_i=1, pc_i=0x3FFFFFFF -> alu_a_o=0x3FFFFFFF; with a_mux_sel_i=0, asel_i=3 -> alu_a_o=0x12; with bsel_i=7, b_mux_sel_i=0 -> alu_b_o=0x34.
REQ-037 Drive imm16_i=0x8001, imm22_i=0x200000 -> alu_b_o = 0xFFFF8001, 0xFFE00000 and 0x00000002 for b_mux_sel_i = 1, 2 and 3; with imm16_i=0x7FFF and sel 1 -> 0x00007FFF.
REQ-038 Write r15=0xA5A5A5A5 and set csel_i=15, asel_i=15, bsel_i=15 -> all three ports read 0xA5A5A5A5.
REQ-039 Pulse rst_ni low mid-cycle, between clock edges -> cdata_o drops to 0 at once, without waiting for a clock edge.
